// File: rtl/timer_pkg.sv
// Shared types for the countdown timer controller: state encoding and widths.
package timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status bundle between the panel + digit counters and the controller.
interface timer_ctrl_if;
    import timer_pkg::*;

    logic               start;
    logic               stop;
    logic               load;
    logic               door_closed;
    logic               zero;
    logic               loadn;
    logic               enable;
    logic               cook_on;
    logic               beep;
    logic [STATE_W-1:0] state;

    // Environment side: buttons, door switch and the digit counters.
    modport master (
        output start, stop, load, door_closed, zero,
        input  loadn, enable, cook_on, beep, state
    );

    // Controller side.
    modport slave (
        input  start, stop, load, door_closed, zero,
        output loadn, enable, cook_on, beep, state
    );

endinterface

// File: rtl/timer_ctrl_rise_detect.sv
// Rising-edge detector for a debounced button level. The stored level resets
// to 1 so a button held through reset release never looks like a fresh press.
module rise_detect (
    input  logic clock,
    input  logic clr,
    input  logic in,
    output logic rise
);

    logic in_q;

    // Remember last cycle's button level.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/done controller: 1 Hz prescaler, door interlock, load strobe,
// decrement strobe to the digit counters and the end-of-count beeper.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int TICKS_PER_SEC  = 50_000_000,
    parameter int DONE_BEEP_SECS = 3
) (
    input  logic         clock,
    input  logic         clr,
    timer_ctrl_if.slave  bus
);

    localparam int PRESC_W = $clog2(TICKS_PER_SEC);
    localparam int SEC_W   = $clog2(DONE_BEEP_SECS + 1);

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(DONE_BEEP_SECS - 1);

    state_t               state_q;
    logic                 loadn_q;
    logic                 enable_q;
    logic                 cook_on_q;
    logic                 beep_q;
    logic [PRESC_W-1:0]   presc_q;
    logic [SEC_W-1:0]     sec_q;

    logic                 start_rise;
    logic                 stop_rise;
    logic                 load_rise;
    logic                 start_ok;
    logic                 presc_tc;

    rise_detect u_start_rise (
        .clock (clock),
        .clr   (clr),
        .in    (bus.start),
        .rise  (start_rise)
    );

    rise_detect u_stop_rise (
        .clock (clock),
        .clr   (clr),
        .in    (bus.stop),
        .rise  (stop_rise)
    );

    rise_detect u_load_rise (
        .clock (clock),
        .clr   (clr),
        .in    (bus.load),
        .rise  (load_rise)
    );

    // A start press only counts with the door shut and time left on the digits.
    assign start_ok = start_rise & bus.door_closed & ~bus.zero;
    assign presc_tc = (presc_q == PRESC_LAST);

    // Main FSM: state, prescaler, beep seconds and all registered outputs.
    // cook_on/beep are updated together with every state change so they
    // always decode the state register. In IDLE a load press wins over start.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q   <= IDLE;
            loadn_q   <= 1'b1;
            enable_q  <= 1'b0;
            cook_on_q <= 1'b0;
            beep_q    <= 1'b0;
            presc_q   <= '0;
            sec_q     <= '0;
        end else begin
            loadn_q  <= 1'b1;
            enable_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load_rise) begin
                        loadn_q <= 1'b0;
                    end else if (start_ok) begin
                        state_q   <= RUN;
                        cook_on_q <= 1'b1;
                        presc_q   <= '0;
                    end
                end
                RUN: begin
                    if (stop_rise || !bus.door_closed) begin
                        state_q   <= PAUSE;
                        cook_on_q <= 1'b0;
                    end else if (bus.zero) begin
                        state_q   <= DONE;
                        cook_on_q <= 1'b0;
                        beep_q    <= 1'b1;
                        presc_q   <= '0;
                        sec_q     <= '0;
                    end else begin
                        presc_q  <= presc_tc ? '0 : presc_q + 1'b1;
                        enable_q <= presc_tc;
                    end
                end
                PAUSE: begin
                    if (load_rise || stop_rise) begin
                        loadn_q <= ~load_rise;
                        state_q <= IDLE;
                    end else if (start_ok) begin
                        state_q   <= RUN;
                        cook_on_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (load_rise || stop_rise || (presc_tc && sec_q == SEC_LAST)) begin
                        loadn_q <= ~load_rise;
                        state_q <= IDLE;
                        beep_q  <= 1'b0;
                        presc_q <= '0;
                        sec_q   <= '0;
                    end else if (presc_tc) begin
                        presc_q <= '0;
                        sec_q   <= sec_q + 1'b1;
                    end else begin
                        presc_q <= presc_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cook_on_q <= 1'b0;
                    beep_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.loadn   = loadn_q;
    assign bus.enable  = enable_q;
    assign bus.cook_on = cook_on_q;
    assign bus.beep    = beep_q;
    assign bus.state   = state_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl with an m:ss digit-counter model in the loop.
module tb_timer_ctrl;

    localparam int T = 4;
    localparam int S = 2;

    logic clock;
    logic clr;

    timer_ctrl_if bus ();

    timer_ctrl #(
        .TICKS_PER_SEC  (T),
        .DONE_BEEP_SECS (S)
    ) dut (
        .clock (clock),
        .clr   (clr),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Digit counter model (minutes mod 10, tens of seconds mod 6, seconds mod 10).
    int preset_secs = 0;
    int min_d  = 0;
    int sect_d = 0;
    int seco_d = 0;

    assign bus.zero = (min_d == 0) && (sect_d == 0) && (seco_d == 0);

    // Reference controller model: tracks state, cycles into the current second
    // while running and total cycles spent beeping.
    int   m_state;
    logic m_loadn;
    logic m_enable;
    logic prev_s, prev_p, prev_l;
    int   m_phase;
    int   m_done_cyc;

    int en_count;
    int ld_count;
    int beep_count;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Digit counters react to the controller strobes.
    always @(posedge clock) begin
        if (!bus.loadn) begin
            min_d  <= (preset_secs / 60) % 10;
            sect_d <= (preset_secs % 60) / 10;
            seco_d <= preset_secs % 10;
        end else if (bus.enable) begin
            if (seco_d != 0) begin
                seco_d <= seco_d - 1;
            end else begin
                seco_d <= 9;
                if (sect_d != 0) begin
                    sect_d <= sect_d - 1;
                end else begin
                    sect_d <= 5;
                    min_d  <= (min_d == 0) ? 9 : min_d - 1;
                end
            end
        end
    end

    function automatic int tm_value();
        return min_d * 60 + sect_d * 10 + seco_d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state    = 0;
        m_loadn    = 1'b1;
        m_enable   = 1'b0;
        prev_s     = 1'b1;
        prev_p     = 1'b1;
        prev_l     = 1'b1;
        m_phase    = 0;
        m_done_cyc = 0;
    endtask

    task automatic model_update(input logic s, input logic p, input logic l,
                                input logic d, input logic z);
        logic sr, pr, lr, ok;
        sr = s & ~prev_s;
        pr = p & ~prev_p;
        lr = l & ~prev_l;
        prev_s = s;
        prev_p = p;
        prev_l = l;
        ok = sr && d && !z;
        m_loadn  = 1'b1;
        m_enable = 1'b0;
        case (m_state)
            0: begin
                if (lr) m_loadn = 1'b0;
                else if (ok) begin
                    m_state = 1;
                    m_phase = 0;
                end
            end
            1: begin
                if (pr || !d) m_state = 2;
                else if (z) begin
                    m_state    = 3;
                    m_done_cyc = 0;
                end else begin
                    m_enable = (m_phase == T - 1);
                    m_phase  = (m_phase + 1) % T;
                end
            end
            2: begin
                if (lr || pr) begin
                    m_loadn = ~lr;
                    m_state = 0;
                end else if (ok) m_state = 1;
            end
            default: begin
                if (lr || pr) begin
                    m_loadn = ~lr;
                    m_state = 0;
                end else begin
                    m_done_cyc++;
                    if (m_done_cyc == T * S) m_state = 0;
                end
            end
        endcase
    endtask

    task automatic checkOutput();
        chk("state",   32'(bus.state),   32'(m_state));
        chk("loadn",   32'(bus.loadn),   32'(m_loadn));
        chk("enable",  32'(bus.enable),  32'(m_enable));
        chk("cook_on", 32'(bus.cook_on), 32'(m_state == 1));
        chk("beep",    32'(bus.beep),    32'(m_state == 3));
    endtask

    // One clock: sample inputs, advance the model, check #1 after the edge.
    task automatic applyStimulus();
        logic s, p, l, d, z;
        s = bus.start;
        p = bus.stop;
        l = bus.load;
        d = bus.door_closed;
        z = bus.zero;
        @(posedge clock);
        if (clr) model_reset();
        else     model_update(s, p, l, d, z);
        #1;
        checkOutput();
        if (bus.enable) en_count++;
        if (!bus.loadn) ld_count++;
        if (bus.beep)   beep_count++;
    endtask

    task automatic press_load(input int secs);
        preset_secs = secs;
        bus.load = 1'b1;
        applyStimulus();
        bus.load = 1'b0;
        applyStimulus();
    endtask

    initial begin
        int lat;
        model_reset();
        bus.start       = 1'b0;
        bus.stop        = 1'b0;
        bus.load        = 1'b0;
        bus.door_closed = 1'b1;
        clr             = 1'b1;
        applyStimulus();
        applyStimulus();
        chk("rst_state",   32'(bus.state),   32'd0);
        chk("rst_loadn",   32'(bus.loadn),   32'd1);
        chk("rst_enable",  32'(bus.enable),  32'd0);
        chk("rst_cook_on", 32'(bus.cook_on), 32'd0);
        chk("rst_beep",    32'(bus.beep),    32'd0);
        clr = 1'b0;
        applyStimulus();

        // Load 0:03: exactly one low cycle on loadn.
        ld_count = 0;
        press_load(3);
        applyStimulus();
        applyStimulus();
        chk("load_pulses", 32'(ld_count), 32'd1);
        chk("load_value",  32'(tm_value()), 32'd3);

        // Start held across reset release is not a press.
        bus.start = 1'b1;
        clr = 1'b1;
        applyStimulus();
        clr = 1'b0;
        repeat (4) applyStimulus();
        chk("held_start_idle", 32'(bus.state), 32'd0);
        bus.start = 1'b0;
        applyStimulus();

        // Full run: 3 strobes, 8 beep cycles, back to IDLE, no 4th strobe.
        en_count = 0;
        beep_count = 0;
        bus.start = 1'b1;
        applyStimulus();
        chk("run_cook_on", 32'(bus.cook_on), 32'd1);
        bus.start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            applyStimulus();
            if (bus.state == 2'd0) break;
        end
        chk("run_back_idle", 32'(bus.state), 32'd0);
        chk("run_enables",   32'(en_count),  32'd3);
        chk("run_beep_cyc",  32'(beep_count), 32'd8);
        repeat (8) applyStimulus();
        chk("run_no_4th", 32'(en_count), 32'd3);

        // Interlock: open door two cycles after the first strobe.
        press_load(3);
        bus.start = 1'b1;
        applyStimulus();
        bus.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            if (bus.enable) break;
        end
        chk("first_enable", 32'(bus.enable), 32'd1);
        applyStimulus();
        applyStimulus();
        bus.door_closed = 1'b0;
        applyStimulus();
        chk("door_pause",   32'(bus.state),   32'd2);
        chk("door_cook_on", 32'(bus.cook_on), 32'd0);
        en_count = 0;
        repeat (6) applyStimulus();
        chk("pause_no_enable", 32'(en_count), 32'd0);
        bus.door_closed = 1'b1;
        bus.start = 1'b1;
        applyStimulus();
        bus.start = 1'b0;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus();
            lat++;
            if (bus.enable) break;
        end
        chk("resume_latency", 32'(lat), 32'd2);
        for (int i = 0; i < 40; i++) begin
            applyStimulus();
            if (bus.state == 2'd0) break;
        end
        chk("resume_enables", 32'(en_count), 32'd2);
        chk("resume_idle",    32'(bus.state), 32'd0);
        chk("resume_value",   32'(tm_value()), 32'd0);

        // Rejected starts: digits at zero, then door open.
        bus.start = 1'b1;
        applyStimulus();
        bus.start = 1'b0;
        applyStimulus();
        chk("reject_zero", 32'(bus.state), 32'd0);
        press_load(3);
        bus.door_closed = 1'b0;
        bus.start = 1'b1;
        applyStimulus();
        bus.start = 1'b0;
        applyStimulus();
        chk("reject_door", 32'(bus.state), 32'd0);
        bus.door_closed = 1'b1;
        applyStimulus();

        // Cancel from PAUSE leaves the digits alone.
        bus.start = 1'b1;
        applyStimulus();
        bus.start = 1'b0;
        applyStimulus();
        bus.stop = 1'b1;
        applyStimulus();
        chk("stop_pause", 32'(bus.state), 32'd2);
        bus.stop = 1'b0;
        applyStimulus();
        bus.stop = 1'b1;
        applyStimulus();
        chk("stop_cancel", 32'(bus.state), 32'd0);
        bus.stop = 1'b0;
        chk("cancel_value", 32'(tm_value()), 32'd3);
        applyStimulus();

        // Stop during DONE silences the beeper immediately.
        press_load(1);
        bus.start = 1'b1;
        applyStimulus();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            if (bus.state == 2'd3) break;
        end
        chk("reach_done", 32'(bus.state), 32'd3);
        applyStimulus();
        bus.stop = 1'b1;
        applyStimulus();
        chk("done_stop_state", 32'(bus.state), 32'd0);
        chk("done_stop_beep",  32'(bus.beep),  32'd0);
        bus.stop = 1'b0;
        applyStimulus();

        // Asynchronous clear in the middle of a run.
        press_load(3);
        bus.start = 1'b1;
        applyStimulus();
        bus.start = 1'b0;
        applyStimulus();
        applyStimulus();
        #2;
        clr = 1'b1;
        #1;
        chk("async_state",   32'(bus.state),   32'd0);
        chk("async_cook_on", 32'(bus.cook_on), 32'd0);
        chk("async_enable",  32'(bus.enable),  32'd0);
        model_reset();
        applyStimulus();
        clr = 1'b0;
        en_count = 0;
        repeat (10) applyStimulus();
        chk("post_clr_enable", 32'(en_count),  32'd0);
        chk("post_clr_state",  32'(bus.state), 32'd0);

        // Random buttons, door and presets against the reference model.
        for (int i = 0; i < 600; i++) begin
            bus.start       = ($urandom_range(0, 5) == 0);
            bus.stop        = ($urandom_range(0, 11) == 0);
            bus.load        = ($urandom_range(0, 11) == 0);
            bus.door_closed = ($urandom_range(0, 19) != 0);
            clr             = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 7) == 0) preset_secs = $urandom_range(0, 4);
            applyStimulus();
        end
        clr = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
